decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter COUNT_W, default 32, meaning the width of the decoded-instruction counter.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid  input  1  fetch presents an instruction.
REQ-005 The block SHALL have port in_ready  output  1  block can accept; driven from a register.
REQ-006 The block SHALL have ports in_instr  input  32  and in_pc  input  32  carrying the instruction word and its PC.
REQ-007 The block SHALL have port flush  input  1  discard all held and incoming instructions.
REQ-008 The block SHALL have port out_valid  output  1  decoded entry available.
REQ-009 The block SHALL have port out_ready  input  1  execute stage consumes the entry.
REQ-010 The block SHALL have ports out_pc  output  32, is_lui, is_i_type, is_branch, rd_we, illegal  output  1 each, alu_ops  output  4, imm  output  32, rs1_addr, rs2_addr, rd_addr  output  5 each, carrying the decoded fields of the head entry.
REQ-011 The block SHALL have port decoded_count  output  COUNT_W  number of output handshakes since reset.

Function
REQ-012 Decode SHALL be: LUI (0110111) -> is_lui=1, imm={12'b0, instr[31:12]}, rd_we=1, alu_ops 0000.
REQ-013 OP-IMM (0010011) SHALL set is_i_type=1, imm=sign-extended instr[31:20], rd_we=1; funct3 000 -> alu_ops 0000, 100 -> 0010; any other funct3 is illegal.
REQ-014 OP (0110011) SHALL set rd_we=1 with alu_ops mapped from {funct7,funct3}: ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, SLT 1001, MUL 1100, DIV 1101; any other combination is illegal.
REQ-015 BRANCH (1100011) SHALL set is_branch=1, rd_we=0, imm=sign-extended B-type offset, and alu_ops={1'b0,funct3}.
REQ-016 Any other opcode, or any illegal combination above, SHALL produce an entry with illegal=1, all is_* flags 0, rd_we=0, alu_ops 0000 and imm 0.
REQ-017 rs1_addr, rs2_addr and rd_addr SHALL always equal instr[19:15], instr[24:20] and instr[11:7].
REQ-018 Storage SHALL be a 2-entry skid buffer with states EMPTY, ONE and TWO.
REQ-019 An input handshake SHALL occur when in_valid and in_ready are both high.
REQ-020 An output handshake SHALL occur when out_valid and out_ready are both high.
REQ-021 The decoded entry SHALL appear on the outputs with out_valid=1 in the cycle after its input handshake when the buffer was EMPTY: latency 1.
REQ-022 State transitions SHALL be: EMPTY -> ONE on input handshake; ONE -> TWO on input without output; ONE -> EMPTY on output without input; ONE stays ONE on simultaneous input and output; TWO -> ONE on output.
REQ-023 in_ready SHALL equal (state != TWO), registered.
REQ-024 Order SHALL be preserved: the head entry is always the oldest one.
REQ-025 While out_valid=1 and out_ready=0, all out_* fields SHALL hold stable.
REQ-026 Flush SHALL go to EMPTY on the next edge and drop any input handshaken in the same cycle.
REQ-027 Flush SHALL take priority over every other event, and a flushed entry SHALL NOT increment decoded_count.
REQ-028 decoded_count SHALL increment by 1 on each output handshake, illegal entries included, and wrap modulo 2^COUNT_W.

Reset
REQ-029 When rst is high at a clock edge, the block SHALL go to EMPTY and set out_valid=0, in_ready=1 and decoded_count=0.
REQ-030 Data outputs SHALL reset to 0, and rst SHALL override flush and any handshake in the same cycle, including mid-transfer.

Structure
REQ-031 A shared package rv32i_pkg SHALL hold the opcode constants, the 4-bit ALU operation codes (values in REQ-014) and the skid-state enum.
REQ-032 The pure combinational instruction-to-fields decoder SHALL be one sub-module, instr_decoder, instantiated once on the input side.

Verification
REQ-033 Sending 0x002081B3 (ADD x3,x1,x2) into an empty block SHALL give, one cycle later, out_valid=1, alu_ops 0000, rs1 1, rs2 2, rd 3, rd_we 1.
REQ-034 Sending 0x123452B7 (LUI x5) SHALL give is_lui 1, imm 0x00012345, rd 5; sending 0xFFF00093 (ADDI x1,x0,-1) SHALL give is_i_type 1, imm 0xFFFFFFFF.
REQ-035 Sending 0xFE000EE3 (BEQ -4) SHALL give is_branch 1, imm 0xFFFFFFFC, rd_we 0; sending 0x0000007F SHALL give illegal 1.
REQ-036 Holding out_ready=0 and offering 3 instructions SHALL make in_ready fall after 2 accepts; raising out_ready SHALL then deliver all 3 in order with stable fields while stalled.
REQ-037 Asserting flush with 2 entries held plus a concurrent input SHALL give out_valid=0 and in_ready=1 next cycle, with decoded_count unchanged.
REQ-038 With COUNT_W=4, 17 output handshakes SHALL leave decoded_count at 1, and rst asserted mid-stream SHALL clear all state in one cycle.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32 decode stage.
//   - opcode constants for the instruction classes the decoder understands
//   - 4-bit ALU operation codes
//   - decoded-entry record carried through the skid buffer
//   - skid buffer occupancy states
//   - lookup from {funct7, funct3} to an ALU code for register-register ops
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b1001;
  localparam logic [3:0] ALU_MUL = 4'b1100;
  localparam logic [3:0] ALU_DIV = 4'b1101;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        is_lui;
    logic        is_i_type;
    logic        is_branch;
    logic        rd_we;
    logic        illegal;
    logic [3:0]  alu_ops;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } decoded_t;

  // Returns {legal, alu_code}; legal=0 for any unsupported combination.
  function automatic logic [4:0] op_alu_lookup(input logic [6:0] funct7,
                                               input logic [2:0] funct3);
    logic [4:0] res;
    res = 5'b0;
    case ({funct7, funct3})
      {7'b0000000, 3'b000}: res = {1'b1, ALU_ADD};
      {7'b0100000, 3'b000}: res = {1'b1, ALU_SUB};
      {7'b0000000, 3'b100}: res = {1'b1, ALU_XOR};
      {7'b0000000, 3'b110}: res = {1'b1, ALU_OR};
      {7'b0000000, 3'b111}: res = {1'b1, ALU_AND};
      {7'b0000000, 3'b001}: res = {1'b1, ALU_SLL};
      {7'b0000000, 3'b101}: res = {1'b1, ALU_SRL};
      {7'b0000000, 3'b010}: res = {1'b1, ALU_SLT};
      {7'b0000001, 3'b000}: res = {1'b1, ALU_MUL};
      {7'b0000001, 3'b100}: res = {1'b1, ALU_DIV};
      default:              res = 5'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Pure combinational instruction-to-fields decoder.
// Ports:
//   instr_i  [31:0] instruction word
//   pc_i     [31:0] PC of the instruction (passed through)
//   dec_o           decoded entry (decoded_t)
// Register addresses are always taken from the fixed RV32 bit positions,
// even for illegal instructions; every other field is cleared when illegal.
module instr_decoder
  import rv32i_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output decoded_t    dec_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] op_lookup;
  logic       bad;

  assign opcode    = instr_i[6:0];
  assign funct3    = instr_i[14:12];
  assign funct7    = instr_i[31:25];
  assign op_lookup = op_alu_lookup(funct7, funct3);

  always_comb begin
    dec_o     = '0;
    bad       = 1'b0;
    dec_o.pc  = pc_i;
    dec_o.rs1 = instr_i[19:15];
    dec_o.rs2 = instr_i[24:20];
    dec_o.rd  = instr_i[11:7];

    case (opcode)
      OPC_LUI: begin
        // Upper immediate is delivered right-aligned, not shifted into place.
        dec_o.is_lui  = 1'b1;
        dec_o.rd_we   = 1'b1;
        dec_o.alu_ops = ALU_ADD;
        dec_o.imm     = {12'b0, instr_i[31:12]};
      end
      OPC_OP_IMM: begin
        dec_o.is_i_type = 1'b1;
        dec_o.rd_we     = 1'b1;
        dec_o.imm       = {{20{instr_i[31]}}, instr_i[31:20]};
        case (funct3)
          3'b000:  dec_o.alu_ops = ALU_ADD;
          3'b100:  dec_o.alu_ops = ALU_XOR;
          default: bad = 1'b1;
        endcase
      end
      OPC_OP: begin
        dec_o.rd_we   = 1'b1;
        dec_o.alu_ops = op_lookup[3:0];
        bad           = ~op_lookup[4];
      end
      OPC_BRANCH: begin
        dec_o.is_branch = 1'b1;
        dec_o.alu_ops   = {1'b0, funct3};
        dec_o.imm       = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
      end
      default: bad = 1'b1;
    endcase

    if (bad) begin
      dec_o.is_lui    = 1'b0;
      dec_o.is_i_type = 1'b0;
      dec_o.is_branch = 1'b0;
      dec_o.rd_we     = 1'b0;
      dec_o.alu_ops   = 4'b0000;
      dec_o.imm       = 32'b0;
      dec_o.illegal   = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes incoming instructions and holds them in a 2-entry
// skid buffer between fetch and execute.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            fetch handshake (in_ready is registered)
//   in_instr, in_pc              instruction word and its PC
//   flush                        drop everything held and incoming
//   out_valid/out_ready          execute handshake
//   out_pc, is_lui, is_i_type,
//   is_branch, rd_we, illegal,
//   alu_ops, imm, rs1_addr,
//   rs2_addr, rd_addr            decoded fields of the head (oldest) entry
//   decoded_count                output handshakes since reset, wrapping
module decode_stage
  import rv32i_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [31:0]        in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic               is_lui,
  output logic               is_i_type,
  output logic               is_branch,
  output logic               rd_we,
  output logic               illegal,
  output logic [3:0]         alu_ops,
  output logic [31:0]        imm,
  output logic [4:0]         rs1_addr,
  output logic [4:0]         rs2_addr,
  output logic [4:0]         rd_addr,
  output logic [COUNT_W-1:0] decoded_count
);

  skid_state_e        state_q, state_d;
  decoded_t           head_q, head_d;
  decoded_t           tail_q, tail_d;
  logic               in_ready_q;
  logic [COUNT_W-1:0] count_q, count_d;
  decoded_t           dec;
  logic               in_hs;
  logic               out_hs;

  instr_decoder u_instr_decoder (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .dec_o   (dec)
  );

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign in_hs     = in_valid && in_ready_q;
  assign out_hs    = out_valid && out_ready;

  // Head register always holds the oldest entry; tail only fills when the
  // head is stalled, so order is preserved without any pointer logic.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      // Flush discards held entries and any concurrent handshake, and the
      // output handshake of a flushed entry is not counted.
      state_d = ST_EMPTY;
    end else begin
      if (out_hs) begin
        count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
      case (state_q)
        ST_EMPTY: begin
          if (in_hs) begin
            head_d  = dec;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_hs && out_hs) begin
            head_d = dec;
          end else if (in_hs) begin
            tail_d  = dec;
            state_d = ST_TWO;
          end else if (out_hs) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the output side can move.
          if (out_hs) begin
            head_d  = tail_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= (state_d != ST_TWO);
      count_q    <= count_d;
    end
  end

  assign out_pc        = head_q.pc;
  assign is_lui        = head_q.is_lui;
  assign is_i_type     = head_q.is_i_type;
  assign is_branch     = head_q.is_branch;
  assign rd_we         = head_q.rd_we;
  assign illegal       = head_q.illegal;
  assign alu_ops       = head_q.alu_ops;
  assign imm           = head_q.imm;
  assign rs1_addr      = head_q.rs1;
  assign rs2_addr      = head_q.rs2;
  assign rd_addr       = head_q.rd;
  assign decoded_count = count_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic        is_lui, is_i_type, is_branch, rd_we, illegal;
  logic [3:0]  alu_ops;
  logic [31:0] imm;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [3:0]  decoded_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage #(.COUNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .is_lui        (is_lui),
    .is_i_type     (is_i_type),
    .is_branch     (is_branch),
    .rd_we         (rd_we),
    .illegal       (illegal),
    .alu_ops       (alu_ops),
    .imm           (imm),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rd_addr       (rd_addr),
    .decoded_count (decoded_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  // Present one instruction for a single cycle; returns at the negedge after
  // the accepting edge, where the entry is on the outputs.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(negedge clk);
    in_valid = 1'b0;
    $display("sent instr=0x%08h pc=0x%08h", instr, pc);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", decoded_count, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_imm", imm, 0);
    rst = 1'b0;
    @(negedge clk);

    // ADD x3,x1,x2
    send(32'h002081B3, 32'h100);
    chk("add_valid", out_valid, 1);
    chk("add_alu", alu_ops, 4'b0000);
    chk("add_rs1", rs1_addr, 1);
    chk("add_rs2", rs2_addr, 2);
    chk("add_rd", rd_addr, 3);
    chk("add_rdwe", rd_we, 1);
    chk("add_pc", out_pc, 32'h100);
    chk("add_illegal", illegal, 0);
    @(negedge clk);
    chk("add_count", decoded_count, 1);
    chk("add_drained", out_valid, 0);

    // LUI x5,0x12345
    send(32'h123452B7, 32'h104);
    chk("lui_flag", is_lui, 1);
    chk("lui_imm", imm, 32'h00012345);
    chk("lui_rd", rd_addr, 5);
    chk("lui_rdwe", rd_we, 1);
    @(negedge clk);
    chk("lui_count", decoded_count, 2);

    // ADDI x1,x0,-1
    send(32'hFFF00093, 32'h108);
    chk("addi_flag", is_i_type, 1);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    chk("addi_alu", alu_ops, 4'b0000);
    @(negedge clk);

    // BEQ -4
    send(32'hFE000EE3, 32'h10C);
    chk("beq_flag", is_branch, 1);
    chk("beq_imm", imm, 32'hFFFFFFFC);
    chk("beq_rdwe", rd_we, 0);
    chk("beq_alu", alu_ops, 4'b0000);
    @(negedge clk);

    // Unknown opcode
    send(32'h0000007F, 32'h110);
    chk("ill_flag", illegal, 1);
    chk("ill_rdwe", rd_we, 0);
    chk("ill_imm", imm, 0);
    @(negedge clk);

    // SUB x2,x1,x2
    send(32'h40208133, 32'h114);
    chk("sub_alu", alu_ops, 4'b0001);
    @(negedge clk);

    // MUL x2,x1,x2
    send(32'h02208133, 32'h118);
    chk("mul_alu", alu_ops, 4'b1100);
    @(negedge clk);

    // XORI x1,x1,-1
    send(32'hFFF0C093, 32'h11C);
    chk("xori_alu", alu_ops, 4'b0010);
    chk("xori_imm", imm, 32'hFFFFFFFF);
    @(negedge clk);

    // SLLI is not supported on the immediate path
    send(32'h00109093, 32'h120);
    chk("slli_illegal", illegal, 1);
    chk("slli_itype", is_i_type, 0);
    chk("slli_imm", imm, 0);
    @(negedge clk);

    // funct7=0100000 with XOR funct3 is not a defined op
    send(32'h4020C133, 32'h124);
    chk("badop_illegal", illegal, 1);
    chk("badop_alu", alu_ops, 0);
    @(negedge clk);
    chk("singles_count", decoded_count, 10);

    // Stall: three offers with out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h200;
    @(negedge clk);
    chk("stall_ready1", in_ready, 1);
    chk("stall_pcA", out_pc, 32'h200);
    in_instr = 32'h123452B7; in_pc = 32'h204;
    @(negedge clk);
    chk("stall_ready2", in_ready, 0);
    chk("stall_pcA2", out_pc, 32'h200);
    in_instr = 32'hFFF00093; in_pc = 32'h208;
    @(negedge clk);
    chk("stall_ready3", in_ready, 0);
    chk("stall_pcA3", out_pc, 32'h200);
    chk("stall_rdA3", rd_addr, 3);
    chk("stall_luiA3", is_lui, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_pcB", out_pc, 32'h204);
    chk("drain_luiB", is_lui, 1);
    chk("drain_ready", in_ready, 1);
    chk("drain_cnt1", decoded_count, 11);
    @(negedge clk);
    in_valid = 1'b0;
    chk("drain_pcC", out_pc, 32'h208);
    chk("drain_itypeC", is_i_type, 1);
    chk("drain_cnt2", decoded_count, 12);
    @(negedge clk);
    chk("drain_empty", out_valid, 0);
    chk("drain_cnt3", decoded_count, 13);

    // Flush with two held entries plus a concurrent input
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h300;
    @(negedge clk);
    in_pc = 32'h304;
    @(negedge clk);
    chk("fl_full", in_ready, 0);
    flush = 1'b1; out_ready = 1'b1; in_pc = 32'h308;
    @(negedge clk);
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_count", decoded_count, 13);
    // Flush while empty drops an input handshaken in the same cycle
    in_pc = 32'h30C;
    @(negedge clk);
    chk("fl_drop_in", out_valid, 0);
    chk("fl_count2", decoded_count, 13);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);

    // Reset mid-stream with buffer full and handshakes pending
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h400;
    @(negedge clk);
    @(negedge clk);
    chk("mr_full", in_ready, 0);
    rst = 1'b1; out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("mr_valid", out_valid, 0);
    chk("mr_ready", in_ready, 1);
    chk("mr_count", decoded_count, 0);
    chk("mr_pc", out_pc, 0);
    chk("mr_imm", imm, 0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);

    // 17 back-to-back handshakes wrap a 4-bit counter to 1
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h500;
    repeat (17) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_count", decoded_count, 1);
    chk("wrap_empty", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
